// File: rtl/pipe_trace_buffer_pkg.sv
// pipe_trace_buffer_pkg
// Shared definitions for the pipeline trace buffer. It holds the trace FSM
// state encoding, the pipeline stage codes carried in each trace record, and
// the trigger qualification helper.
package pipe_trace_buffer_pkg;

  // The encoding is visible on the trc_state port, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } trc_state_t;

  // Stage code 0 marks a slot with no real pipeline record, so it is never stored.
  localparam logic [1:0] STAGE_NONE    = 2'd0;
  localparam logic [1:0] STAGE_FETCH   = 2'd1;
  localparam logic [1:0] STAGE_DECODE  = 2'd2;
  localparam logic [1:0] STAGE_EXECUTE = 2'd3;

  // A record triggers when it is valid and is either an illegal instruction
  // or a match on the enabled trigger PC.
  function automatic logic is_trigger(input logic valid,
                                      input logic illegal,
                                      input logic pc_en,
                                      input logic pc_match);
    return valid & (illegal | (pc_en & pc_match));
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_if.sv
// pipe_trace_buffer_if
// Bundles the capture-side record bus and the readout handshake.
//   capture: cap_valid, cap_stage[1:0], cap_pc, cap_word, cap_illegal
//   readout: rd_valid, rd_ready, rd_stage[1:0], rd_pc, rd_word
// Modports:
//   master - the pipeline/consumer side (drives the records and rd_ready)
//   slave  - the trace buffer (drives the readout fields)
interface pipe_trace_buffer_if #(
  parameter int WORD_W = 16
) ();
  logic              cap_valid;
  logic [1:0]        cap_stage;
  logic [WORD_W-1:0] cap_pc;
  logic [WORD_W-1:0] cap_word;
  logic              cap_illegal;

  logic              rd_valid;
  logic              rd_ready;
  logic [1:0]        rd_stage;
  logic [WORD_W-1:0] rd_pc;
  logic [WORD_W-1:0] rd_word;

  modport master (
    output cap_valid, cap_stage, cap_pc, cap_word, cap_illegal, rd_ready,
    input  rd_valid, rd_stage, rd_pc, rd_word
  );

  modport slave (
    input  cap_valid, cap_stage, cap_pc, cap_word, cap_illegal, rd_ready,
    output rd_valid, rd_stage, rd_pc, rd_word
  );
endinterface

// File: rtl/pipe_trace_buffer_trace_ram.sv
// trace_ram
// Trace storage: DEPTH entries of DATA_W bits. It has one synchronous write
// port and one asynchronous read port. The contents are not reset.
// Ports:
//   clk     - clock; writes happen on the rising edge
//   wr_en   - write enable
//   wr_addr - write address
//   wr_data - write data
//   rd_addr - read address
//   rd_data - read data (combinational)
module trace_ram #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 34
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer
// Circular trace buffer for pipeline records. After it is armed, it keeps the
// most recent DEPTH records. A trigger is an illegal instruction or a PC
// match. After the trigger it takes POST_TRIG more records, then freezes and
// raises halt_req. The held entries are then drained oldest-first through a
// valid/ready readout.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   arm                 - start a new capture (only honoured in IDLE)
//   trig_pc_en, trig_pc - PC-match trigger enable and value
//   bus                 - capture records in, readout entries out
//   count               - number of entries held
//   trc_state           - FSM state (IDLE/CAPTURE/POST/DONE)
//   overflow            - sticky: an old entry was overwritten
//   halt_req            - high exactly while the buffer is in DONE
module pipe_trace_buffer
  import pipe_trace_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int WORD_W    = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   trig_pc_en,
  input  logic [WORD_W-1:0]      trig_pc,
  pipe_trace_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             trc_state,
  output logic                   overflow,
  output logic                   halt_req
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 + 2 * WORD_W;
  localparam logic [PTR_W-1:0] POST_INIT = PTR_W'(POST_TRIG);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  trc_state_t         state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   post_cnt;
  logic [CNT_W-1:0]   cnt;

  logic               capturing;
  logic               wr_en;
  logic               trig;
  logic               full;
  logic               pop;
  logic [ENTRY_W-1:0] rd_entry;

  assign capturing = (state == ST_CAPTURE) || (state == ST_POST);
  assign wr_en     = capturing && bus.cap_valid && (bus.cap_stage != STAGE_NONE);
  // Trigger only counts for a record that is actually stored, so the trigger
  // record is always present in the trace.
  assign trig      = wr_en && is_trigger(bus.cap_valid, bus.cap_illegal,
                                         trig_pc_en, bus.cap_pc == trig_pc);
  assign full      = (cnt == FULL_CNT);
  assign pop       = (state == ST_DONE) && (cnt != '0) && bus.rd_ready;

  trace_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({bus.cap_stage, bus.cap_pc, bus.cap_word}),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  // Pointer, count and FSM update. A write to a full buffer advances both
  // pointers, so the oldest entry is dropped and the count stays at DEPTH.
  // The readout pop that empties the buffer returns the FSM to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      post_cnt <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            post_cnt <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            state    <= ST_CAPTURE;
          end
        end
        ST_CAPTURE, ST_POST: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (full) begin
              rd_ptr   <= rd_ptr + PTR_W'(1);
              overflow <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
            if (state == ST_CAPTURE) begin
              if (trig) begin
                if (POST_TRIG > 0) begin
                  post_cnt <= POST_INIT;
                  state    <= ST_POST;
                end else begin
                  state <= ST_DONE;
                end
              end
            end else begin
              post_cnt <= post_cnt - PTR_W'(1);
              if (post_cnt == PTR_W'(1)) begin
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_valid = (state == ST_DONE) && (cnt != '0);
  assign bus.rd_stage = rd_entry[ENTRY_W-1 -: 2];
  assign bus.rd_pc    = rd_entry[2*WORD_W-1 -: WORD_W];
  assign bus.rd_word  = rd_entry[WORD_W-1:0];

  assign count     = cnt;
  assign trc_state = state;
  assign halt_req  = (state == ST_DONE);

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb_pipe_trace_buffer
// Self-checking bench. dut_a has POST_TRIG=0 and dut_b has POST_TRIG=4. Both
// see the same capture bus. Each has its own arm and rd_ready, so only the
// armed instance records anything.
module tb_pipe_trace_buffer;
  import pipe_trace_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm_a, arm_b;
  logic        trig_pc_en;
  logic [15:0] trig_pc;
  logic [4:0]  count_a, count_b;
  logic [1:0]  state_a, state_b;
  logic        ovf_a, ovf_b, halt_a, halt_b;

  int checks = 0;
  int errors = 0;

  pipe_trace_buffer_if #(.WORD_W(16)) bus_a ();
  pipe_trace_buffer_if #(.WORD_W(16)) bus_b ();

  assign bus_b.cap_valid   = bus_a.cap_valid;
  assign bus_b.cap_stage   = bus_a.cap_stage;
  assign bus_b.cap_pc      = bus_a.cap_pc;
  assign bus_b.cap_word    = bus_a.cap_word;
  assign bus_b.cap_illegal = bus_a.cap_illegal;

  pipe_trace_buffer #(.DEPTH(16), .WORD_W(16), .POST_TRIG(0)) dut_a (
    .clk(clk), .reset(reset), .arm(arm_a), .trig_pc_en(trig_pc_en),
    .trig_pc(trig_pc), .bus(bus_a), .count(count_a), .trc_state(state_a),
    .overflow(ovf_a), .halt_req(halt_a)
  );

  pipe_trace_buffer #(.DEPTH(16), .WORD_W(16), .POST_TRIG(4)) dut_b (
    .clk(clk), .reset(reset), .arm(arm_b), .trig_pc_en(trig_pc_en),
    .trig_pc(trig_pc), .bus(bus_b), .count(count_b), .trc_state(state_b),
    .overflow(ovf_b), .halt_req(halt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        arm;
    logic        cv;
    logic [1:0]  stg;
    logic [15:0] pc;
    logic [15:0] word;
    logic        ill;
    logic        rdy;
    logic [1:0]  e_state;
    int          e_count;
    logic        e_valid;
    logic [1:0]  e_stage;
    logic [15:0] e_pc;
    logic [15:0] e_word;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic a, logic cv, logic [1:0] stg, logic [15:0] pc,
                              logic [15:0] word, logic ill, logic rdy,
                              logic [1:0] es, int ec, logic ev, logic [1:0] estg,
                              logic [15:0] epc, logic [15:0] ew);
    vec_t v;
    v.arm = a; v.cv = cv; v.stg = stg; v.pc = pc; v.word = word; v.ill = ill;
    v.rdy = rdy; v.e_state = es; v.e_count = ec; v.e_valid = ev;
    v.e_stage = estg; v.e_pc = epc; v.e_word = ew;
    return v;
  endfunction

  // Compare one value and report it if it differs.
  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of capture/readout inputs on dut_a, then step one clock.
  task automatic applyStimulus(input vec_t v);
    arm_a             = v.arm;
    bus_a.cap_valid   = v.cv;
    bus_a.cap_stage   = v.stg;
    bus_a.cap_pc      = v.pc;
    bus_a.cap_word    = v.word;
    bus_a.cap_illegal = v.ill;
    bus_a.rd_ready    = v.rdy;
    @(posedge clk); #1;
    arm_a = 1'b0;
  endtask

  // Drive one capture record with no arm and no ready, then step one clock.
  task automatic step(input logic cv, input logic [1:0] stg, input logic [15:0] pc,
                      input logic ill);
    bus_a.cap_valid   = cv;
    bus_a.cap_stage   = stg;
    bus_a.cap_pc      = pc;
    bus_a.cap_word    = pc ^ 16'h5A5A;
    bus_a.cap_illegal = ill;
    @(posedge clk); #1;
    bus_a.cap_valid   = 1'b0;
    bus_a.cap_illegal = 1'b0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  int pcs_b[7] = '{60, 62, 64, 66, 68, 70, 72};

  initial begin
    reset = 1'b1; arm_a = 1'b0; arm_b = 1'b0;
    trig_pc_en = 1'b0; trig_pc = 16'd0;
    bus_a.cap_valid = 1'b0; bus_a.cap_stage = 2'd0; bus_a.cap_pc = '0;
    bus_a.cap_word = '0; bus_a.cap_illegal = 1'b0;
    bus_a.rd_ready = 1'b0; bus_b.rd_ready = 1'b0;
    #2;
    checkOutput("rst_state_a", 0, 32'(state_a), 32'(ST_IDLE));
    checkOutput("rst_count_a", 0, 32'(count_a), 0);
    checkOutput("rst_halt_a",  0, 32'(halt_a), 0);
    checkOutput("rst_valid_a", 0, 32'(bus_a.rd_valid), 0);
    checkOutput("rst_state_b", 0, 32'(state_b), 32'(ST_IDLE));
    checkOutput("rst_ovf_b",   0, 32'(ovf_b), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Illegal-instruction trigger with no post records, then readout with a
    // stalling consumer, arm ignored in DONE and capture ignored in IDLE.
    vecs[0]  = mk(1, 0, 0, 0,  0,       0, 0, ST_CAPTURE, 0, 0, 0, 0,  0);
    vecs[1]  = mk(0, 1, 1, 8,  16'hA001, 0, 0, ST_CAPTURE, 1, 0, 0, 0,  0);
    vecs[2]  = mk(0, 1, 2, 10, 16'hA002, 0, 0, ST_CAPTURE, 2, 0, 0, 0,  0);
    vecs[3]  = mk(0, 1, 3, 12, 16'h0030, 1, 0, ST_DONE,    3, 1, 1, 8,  16'hA001);
    vecs[4]  = mk(1, 1, 1, 14, 16'h0044, 0, 0, ST_DONE,    3, 1, 1, 8,  16'hA001);
    vecs[5]  = mk(0, 0, 0, 0,  0,       0, 1, ST_DONE,    2, 1, 2, 10, 16'hA002);
    vecs[6]  = mk(0, 0, 0, 0,  0,       0, 0, ST_DONE,    2, 1, 2, 10, 16'hA002);
    vecs[7]  = mk(0, 0, 0, 0,  0,       0, 1, ST_DONE,    1, 1, 3, 12, 16'h0030);
    vecs[8]  = mk(0, 0, 0, 0,  0,       0, 1, ST_IDLE,    0, 0, 0, 0,  0);
    vecs[9]  = mk(0, 1, 1, 20, 16'h0020, 0, 0, ST_IDLE,    0, 0, 0, 0,  0);
    vecs[10] = mk(0, 0, 0, 0,  0,       0, 1, ST_IDLE,    0, 0, 0, 0,  0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput("tbl_state", i, 32'(state_a), 32'(vecs[i].e_state));
      checkOutput("tbl_count", i, 32'(count_a), 32'(vecs[i].e_count));
      checkOutput("tbl_valid", i, 32'(bus_a.rd_valid), 32'(vecs[i].e_valid));
      checkOutput("tbl_halt",  i, 32'(halt_a), 32'(vecs[i].e_state == ST_DONE));
      checkOutput("tbl_ovf",   i, 32'(ovf_a), 0);
      if (vecs[i].e_valid) begin
        checkOutput("tbl_rd_stage", i, 32'(bus_a.rd_stage), 32'(vecs[i].e_stage));
        checkOutput("tbl_rd_pc",    i, 32'(bus_a.rd_pc),    32'(vecs[i].e_pc));
        checkOutput("tbl_rd_word",  i, 32'(bus_a.rd_word),  32'(vecs[i].e_word));
      end
    end

    // Wrap: 20 plain records, then an illegal trigger record. The buffer keeps
    // records 5..20.
    pulseReset();
    arm_a = 1'b1; @(posedge clk); #1; arm_a = 1'b0;
    for (int i = 0; i <= 20; i++) step(1'b1, STAGE_FETCH, 16'(100 + i), i == 20);
    checkOutput("wrap_state", 0, 32'(state_a), 32'(ST_DONE));
    checkOutput("wrap_count", 0, 32'(count_a), 16);
    checkOutput("wrap_ovf",   0, 32'(ovf_a), 1);
    checkOutput("wrap_halt",  0, 32'(halt_a), 1);
    bus_a.rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checkOutput("wrap_valid", k, 32'(bus_a.rd_valid), 1);
      checkOutput("wrap_rd_pc", k, 32'(bus_a.rd_pc), 32'(105 + k));
      @(posedge clk); #1;
    end
    bus_a.rd_ready = 1'b0;
    checkOutput("wrap_end_state", 0, 32'(state_a), 32'(ST_IDLE));
    checkOutput("wrap_end_count", 0, 32'(count_a), 0);

    // PC-match trigger at 0o100 with four post records. A second trigger and
    // a stage-0 record during POST must not affect the post count.
    pulseReset();
    trig_pc_en = 1'b1; trig_pc = 16'd64;
    arm_b = 1'b1; @(posedge clk); #1; arm_b = 1'b0;
    step(1, STAGE_FETCH, 60, 0);
    step(1, STAGE_FETCH, 62, 0);
    checkOutput("post_pre_state", 0, 32'(state_b), 32'(ST_CAPTURE));
    step(1, STAGE_DECODE, 64, 0);
    checkOutput("post_trig_state", 0, 32'(state_b), 32'(ST_POST));
    step(1, STAGE_FETCH, 66, 0);
    step(1, STAGE_FETCH, 68, 1);
    step(1, STAGE_NONE, 69, 0);
    step(1, STAGE_FETCH, 70, 0);
    checkOutput("post_mid_state", 0, 32'(state_b), 32'(ST_POST));
    checkOutput("post_mid_count", 0, 32'(count_b), 6);
    step(1, STAGE_EXECUTE, 72, 0);
    checkOutput("post_done_state", 0, 32'(state_b), 32'(ST_DONE));
    step(1, STAGE_FETCH, 74, 0);
    step(1, STAGE_FETCH, 76, 0);
    checkOutput("post_count", 0, 32'(count_b), 7);
    checkOutput("post_halt",  0, 32'(halt_b), 1);
    checkOutput("post_a_idle", 0, 32'(state_a), 32'(ST_IDLE));
    bus_b.rd_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      checkOutput("post_rd_pc", k, 32'(bus_b.rd_pc), 32'(pcs_b[k]));
      @(posedge clk); #1;
    end
    bus_b.rd_ready = 1'b0;
    checkOutput("post_end_state", 0, 32'(state_b), 32'(ST_IDLE));

    // An asynchronous reset in POST discards everything.
    pulseReset();
    arm_b = 1'b1; @(posedge clk); #1; arm_b = 1'b0;
    step(1, STAGE_FETCH, 64, 0);
    step(1, STAGE_FETCH, 66, 0);
    checkOutput("rstp_pre_state", 0, 32'(state_b), 32'(ST_POST));
    checkOutput("rstp_pre_count", 0, 32'(count_b), 2);
    #2; reset = 1'b1; #1;
    checkOutput("rstp_state", 0, 32'(state_b), 32'(ST_IDLE));
    checkOutput("rstp_count", 0, 32'(count_b), 0);
    checkOutput("rstp_halt",  0, 32'(halt_b), 0);
    checkOutput("rstp_valid", 0, 32'(bus_b.rd_valid), 0);
    @(posedge clk); #1; reset = 1'b0;
    bus_b.rd_ready = 1'b1;
    @(posedge clk); #1;
    bus_b.rd_ready = 1'b0;
    checkOutput("rstp_after_state", 0, 32'(state_b), 32'(ST_IDLE));
    checkOutput("rstp_after_count", 0, 32'(count_b), 0);
    checkOutput("rstp_after_valid", 0, 32'(bus_b.rd_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_trace_buffer.md
PIPE_TRACE_BUFFER -- requirements
Module: pipe_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning trace entries stored; power of two, minimum 4.
REQ-002 SHALL have parameter WORD_W, default 16, meaning width of PC and data words.
REQ-003 SHALL have parameter POST_TRIG, default 4, meaning records captured after the trigger record; range 0..DEPTH-1.
REQ-004 SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port arm, input, 1, meaning start capture when IDLE.
REQ-007 SHALL have port cap_valid, input, 1, meaning a pipeline record is present this cycle.
REQ-008 SHALL have port cap_stage, input, 2, meaning record stage: 1 fetch, 2 decode, 3 execute.
REQ-009 SHALL have port cap_pc, input, WORD_W, meaning program counter of the record.
REQ-010 SHALL have port cap_word, input, WORD_W, meaning instruction word (fetch/decode) or ALU result (execute).
REQ-011 SHALL have port cap_illegal, input, 1, meaning decoder found no valid instruction type.
REQ-012 SHALL have port trig_pc_en, input, 1, meaning enable PC-match trigger.
REQ-013 SHALL have port trig_pc, input, WORD_W, meaning PC-match trigger value.
REQ-014 SHALL have port rd_ready, input, 1, meaning consumer accepts a readout entry.
REQ-015 SHALL have port rd_valid, output, 1, meaning readout entry valid.
REQ-016 SHALL have port rd_stage, rd_pc, rd_word, output, 2/WORD_W/WORD_W, meaning readout entry fields.
REQ-017 SHALL have port count, output, $clog2(DEPTH)+1, meaning entries held.
REQ-018 SHALL have port trc_state, output, 2, meaning FSM state encoding.
REQ-019 SHALL have port overflow, output, 1, meaning sticky flag set when an entry was overwritten.
REQ-020 SHALL have port halt_req, output, 1, meaning request for the CPU to stop, replacing simulation stop.

Function
REQ-021 SHALL implement FSM IDLE(0), CAPTURE(1), POST(2), DONE(3).
REQ-022 IDLE: ignores cap_valid; arm=1 SHALL clear buffer, count, overflow and go to CAPTURE next cycle.
REQ-023 CAPTURE: each cycle with cap_valid=1 and cap_stage!=0 SHALL write one entry; count increments next cycle.
REQ-024 Full buffer with a new write SHALL overwrite the oldest entry, hold count at DEPTH, and set overflow.
REQ-025 Trigger = cap_valid & (cap_illegal | (trig_pc_en & cap_pc==trig_pc)); the trigger record SHALL itself be written.
REQ-026 On trigger in CAPTURE: POST_TRIG>0 SHALL go to POST with post counter=POST_TRIG; POST_TRIG=0 SHALL go directly to DONE.
REQ-027 POST: each written record SHALL decrement the counter; the write reaching 0 SHALL move to DONE; further triggers ignored.
REQ-028 halt_req SHALL be 1 exactly while state is DONE.
REQ-029 DONE: SHALL stop capture; rd_valid=1 while count>0, presenting oldest entry first (combinational from storage).
REQ-030 rd_valid & rd_ready SHALL pop one entry per cycle; pop of last entry SHALL return to IDLE next cycle.
REQ-031 DONE with count=0 on entry is impossible; arm SHALL be ignored outside IDLE.
REQ-032 rd_valid SHALL be 0 in all states except DONE; rd_ready outside DONE SHALL have no effect.
REQ-033 Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-034 reset=1 SHALL asynchronously force IDLE, pointers/count/post counter 0, overflow 0, halt_req 0, rd_valid 0; storage contents need not be cleared.
REQ-035 reset asserted mid-CAPTURE, POST or DONE SHALL discard all entries; no readout follows.

Structure
REQ-036 Trace state enum and stage codes (FETCH=1, DECODE=2, EXECUTE=3) SHALL be in the shared parameters package.
REQ-037 Storage SHALL be a sub-module trace_ram (DEPTH x (2+2*WORD_W), one write port, one async read port).

Verification
REQ-038 arm, 3 records PCs 0o10/0o12/0o14, cap_illegal on third, POST_TRIG=0 -> DONE, halt_req=1, readout 0o10,0o12,0o14, then IDLE.
REQ-039 DEPTH=16, 20 records without trigger, then trigger -> count=16, overflow=1, first readout is record 5 (wrapped).
REQ-040 trig_pc_en=1, trig_pc=0o100, POST_TRIG=4 -> exactly 4 records after the 0o100 record stored; later records dropped.
REQ-041 Readout with rd_ready toggling 1,0,1 -> pops only on ready cycles; order preserved.
REQ-042 reset pulsed during POST -> next cycle IDLE, count=0, halt_req=0, rd_valid=0.
REQ-043 arm asserted in DONE, cap_valid in IDLE -> no state or count change.
